// File: rtl/jk_bank_sequencer.sv
// Sequences one SET/TOGGLE/CLEAR/HOLD command into J/K excitation for a JK bank, checks Q, retries with forcing drive.
// Latency 3 cycles accept-to-done (+2 per retry); in_ready only in IDLE, so commands stall while busy.
module jk_bank_sequencer #(
    parameter int N         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N-1:0] in_target,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         ff_rst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] result
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

    state_t          state, state_d;
    logic [N-1:0]    exp_q, exp_d;
    logic [RW-1:0]   retry_cnt, retry_d;
    logic [N-1:0]    j_d, k_d, result_d;
    logic            ff_rst_d, done_d, err_d;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_d  = state;
        exp_d    = exp_q;
        retry_d  = retry_cnt;
        j_d      = '0;
        k_d      = '0;
        ff_rst_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result;
        case (state)
            INIT: begin
                // ff_rst is held for one cycle, then the bank is known zero
                if (ff_rst) state_d = IDLE;
                else        ff_rst_d = 1'b1;
            end
            IDLE: begin
                if (in_valid) begin
                    state_d = DRIVE;
                    retry_d = '0;
                    case (in_op)
                        OP_SET: begin
                            exp_d = in_target;
                            j_d   = in_target;
                            k_d   = ~in_target;
                        end
                        OP_TOGGLE: begin
                            exp_d = q_fb ^ in_target;
                            j_d   = in_target;
                            k_d   = in_target;
                        end
                        OP_CLEAR: begin
                            exp_d = '0;
                            k_d   = '1;
                        end
                        default: exp_d = q_fb;
                    endcase
                end
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                if (q_fb == exp_q) begin
                    result_d = q_fb;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (retry_cnt < RW'(MAX_RETRY)) begin
                    // retries always force the expected value regardless of op
                    retry_d = retry_cnt + 1'b1;
                    j_d     = exp_q;
                    k_d     = ~exp_q;
                    state_d = DRIVE;
                end else begin
                    result_d = q_fb;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            exp_q     <= '0;
            retry_cnt <= '0;
            j         <= '0;
            k         <= '0;
            ff_rst    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_d;
            exp_q     <= exp_d;
            retry_cnt <= retry_d;
            j         <= j_d;
            k         <= k_d;
            ff_rst    <= ff_rst_d;
            done      <= done_d;
            err       <= err_d;
            result    <= result_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: JK bank with optional stuck-at-0 bits, transaction-level expectation model.
module tb_jk_bank_sequencer;

    localparam int N    = 4;
    localparam int MAXR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [N-1:0] in_target = '0;
    logic [N-1:0] q_fb;
    logic [N-1:0] j, k, result;
    logic         ff_rst, busy, done, err;

    logic [N-1:0] bank  = 4'b1011;
    logic [N-1:0] stuck = 4'b0000;

    jk_bank_sequencer #(.N(N), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_target(in_target), .q_fb(q_fb), .j(j), .k(k),
        .ff_rst(ff_rst), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    assign q_fb = bank;
    always @(posedge clk) begin
        if (ff_rst) bank <= '0;
        else        bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
    end

    typedef struct packed {
        logic [3:0] j;
        logic [3:0] k;
        logic       ffr;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       er;
        logic [3:0] res;
    } exp_t;

    exp_t       sched[$];
    logic [3:0] m_bank = '0;
    logic [3:0] m_result = '0;
    bit         in_rst = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Unroll a whole command into its expected per-cycle outputs.
    function automatic void gen_cmd(input logic [1:0] op, input logic [3:0] tgt);
        logic [3:0] ex, jd, kd;
        exp_t r;
        case (op)
            2'd0:    begin ex = tgt;          jd = tgt;  kd = ~tgt;  end
            2'd1:    begin ex = m_bank ^ tgt; jd = tgt;  kd = tgt;   end
            2'd2:    begin ex = 4'h0;         jd = 4'h0; kd = 4'hF;  end
            default: begin ex = m_bank;       jd = 4'h0; kd = 4'h0;  end
        endcase
        for (int a = 0; a <= MAXR; a++) begin
            r = '0; r.bsy = 1'b1; r.j = jd; r.k = kd; r.res = m_result;
            sched.push_back(r);
            r.j = 4'h0; r.k = 4'h0;
            sched.push_back(r);
            m_bank = ((jd & ~m_bank) | (~kd & m_bank)) & ~stuck;
            if (m_bank == ex || a == MAXR) begin
                m_result = m_bank;
                r = '0; r.rdy = 1'b1; r.dn = 1'b1; r.er = (m_bank != ex); r.res = m_bank;
                sched.push_back(r);
                break;
            end
            jd = ex;
            kd = ~ex;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e, g, r;
        if (!rst) begin
            e = '0; e.bsy = 1'b1;
            sched.delete();
            in_rst   = 1'b1;
            m_result = '0;
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                m_bank = '0;
                r = '0; r.bsy = 1'b1;
                sched.push_back(r);
                r.ffr = 1'b1;
                sched.push_back(r);
            end
            if (sched.size() > 0) e = sched.pop_front();
            else begin
                e = '0; e.rdy = 1'b1; e.res = m_result;
            end
        end
        g.j = j; g.k = k; g.ffr = ff_rst; g.rdy = in_ready; g.bsy = busy;
        g.dn = done; g.er = err; g.res = result;
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL cycle_model t=%0t got j=%b k=%b ffr=%b rdy=%b busy=%b done=%b err=%b res=%b want j=%b k=%b ffr=%b rdy=%b busy=%b done=%b err=%b res=%b",
                     $time, g.j, g.k, g.ffr, g.rdy, g.bsy, g.dn, g.er, g.res,
                     e.j, e.k, e.ffr, e.rdy, e.bsy, e.dn, e.er, e.res);
        end
        if (rst && e.rdy && in_valid) gen_cmd(in_op, in_target);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [3:0] tgt, input bit b2b, input bit keep,
                       input logic [1:0] nxt_op, input logic [3:0] ej, input logic [3:0] ek,
                       input int edrv, input int elat, input logic [3:0] eres, input bit eerr,
                       input string nm);
        int lat, drv, w;
        logic [3:0] sj, sk;
        if (!b2b) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = op; in_target = tgt;
            w = 0;
            do begin @(negedge clk); w++; end while (!in_ready && w < 20);
        end
        chk({nm, "_ready"}, 32'(in_ready), 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (keep) in_op = nxt_op;
        else      in_valid = 1'b0;
        lat = 0; drv = 0; sj = '0; sk = '0;
        do begin
            @(negedge clk);
            lat++;
            if ((|j) || (|k)) begin drv++; sj = j; sk = k; end
        end while (!done && lat < 30);
        chk({nm, "_lat"},    32'(lat),    32'(elat));
        chk({nm, "_drives"}, 32'(drv),    32'(edrv));
        chk({nm, "_j"},      32'(sj),     32'(ej));
        chk({nm, "_k"},      32'(sk),     32'(ek));
        chk({nm, "_result"}, 32'(result), 32'(eres));
        chk({nm, "_err"},    32'(err),    32'(eerr));
    endtask

    task automatic count_ffr(input string nm);
        int cnt;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (ff_rst) cnt++;
        end
        chk({nm, "_ffr_once"}, 32'(cnt), 32'd1);
        chk({nm, "_idle"}, 32'({in_ready, busy, j, k, done, err}), 32'({1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0}));
        chk({nm, "_bank"}, 32'(bank), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'({j, k, ff_rst, in_ready, busy, done, err, result}),
            32'({4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        count_ffr("init");

        run(2'd0, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0101, 1, 3, 4'b1010, 1'b0, "set1010");
        run(2'd1, 4'b0110, 1'b0, 1'b0, 2'd0, 4'b0110, 4'b0110, 1, 3, 4'b1100, 1'b0, "tog0110");

        stuck = 4'b0001;
        run(2'd0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b1110, 3, 7, 4'b0000, 1'b1, "stuck");
        stuck = 4'b0000;

        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'd0; in_target = 4'b1111;
        begin
            int w;
            w = 0;
            do begin @(negedge clk); w++; end while (!in_ready && w < 20);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk("mid_drive_j", 32'({j, k}), 32'({4'hF, 4'h0}));
        rst = 1'b0;
        #1;
        chk("async_rst", 32'({j, k, done, err, in_ready, busy}),
            32'({4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        count_ffr("rerun");

        run(2'd0, 4'b1010, 1'b0, 1'b0, 2'd0, 4'b1010, 4'b0101, 1, 3, 4'b1010, 1'b0, "set_again");
        run(2'd2, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b1111, 1, 3, 4'b0000, 1'b0, "clear");
        run(2'd3, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 0, 3, 4'b0000, 1'b0, "hold_b2b");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
